// File: rtl/led_seq_pkg.sv
// Shared types and pattern helpers for the LED sequencer.
// FSM state codes, display modes and the per-mode initial/step patterns.
package led_seq_pkg;

  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StRun   = 2'd1;
  localparam state_t StPause = 2'd2;

  typedef enum logic [1:0] {
    ModeChase = 2'b00,
    ModeBlink = 2'b01,
    ModeAlt   = 2'b10,
    ModeCount = 2'b11
  } mode_e;

  localparam logic [7:0] InitChase = 8'h01;
  localparam logic [7:0] InitBlink = 8'hFF;
  localparam logic [7:0] InitAlt   = 8'h55;
  localparam logic [7:0] InitCount = 8'h00;

  function automatic logic [7:0] init_pattern(input mode_e mode);
    logic [7:0] pat;
    unique case (mode)
      ModeChase: pat = InitChase;
      ModeBlink: pat = InitBlink;
      ModeAlt:   pat = InitAlt;
      ModeCount: pat = InitCount;
    endcase
    return pat;
  endfunction

  function automatic logic [7:0] step_pattern(input logic [7:0] led, input mode_e mode);
    logic [7:0] pat;
    unique case (mode)
      ModeChase: pat = {led[6:0], led[7]};
      ModeBlink: pat = ~led;
      ModeAlt:   pat = ~led;
      ModeCount: pat = led + 8'd1;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Fractional rate generator: adds a selectable step each enabled cycle and
// emits a registered one-cycle tick whenever the accumulator passes LIMIT.
module tick_gen #(
  parameter int unsigned LIMIT     = 50_000_000,
  parameter int unsigned STEP_SLOW = 2,
  parameter int unsigned STEP_FAST = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  input  logic fast,
  output logic tick
);

  localparam int unsigned StepMax = (STEP_SLOW > STEP_FAST) ? STEP_SLOW : STEP_FAST;
  // acc < LIMIT always, so acc + step < LIMIT + StepMax fits in AccW bits.
  localparam int unsigned AccW    = $clog2(LIMIT + StepMax);

  logic [AccW-1:0] acc_q, acc_d, sum;
  logic            tick_q, tick_d;

  assign sum = acc_q + (fast ? AccW'(STEP_FAST) : AccW'(STEP_SLOW));

  always_comb begin
    acc_d  = acc_q;
    tick_d = 1'b0;
    if (clear) begin
      acc_d = '0;
    end else if (enable) begin
      if (sum >= AccW'(LIMIT)) begin
        acc_d  = sum - AccW'(LIMIT);
        tick_d = 1'b1;
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: IDLE/RUN/PAUSE control, pushbutton synchronizer,
// and a registered pattern register stepped by tick_gen.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned LIMIT     = 50_000_000,
  parameter int unsigned STEP_SLOW = 2,
  parameter int unsigned STEP_FAST = 15
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [3:0] SW,
  input  logic       KEY1_N,
  output logic [7:0] LEDR,
  output logic       TICK
);

  logic       sync1_q, sync2_q, key_prev_q, press;
  state_t     state_q, state_d;
  mode_e      mode_q, sw_mode;
  logic [7:0] led_q, led_d;
  logic       tick, run_en, clear;

  assign sw_mode = mode_e'(SW[3:2]);
  assign press   = key_prev_q & ~sync2_q;
  assign run_en  = (state_q == StRun);
  assign clear   = (state_d == StIdle);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (SW[0]) state_d = StRun;
      StRun: begin
        if (!SW[0])     state_d = StIdle;
        else if (press) state_d = StPause;
      end
      StPause: begin
        if (!SW[0])     state_d = StIdle;
        else if (press) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase
  end

  // A mode change reloads the pattern and swallows any step due that cycle.
  always_comb begin
    led_d = led_q;
    if (state_d == StIdle) begin
      led_d = 8'h00;
    end else if (state_q == StIdle || sw_mode != mode_q) begin
      led_d = init_pattern(sw_mode);
    end else if (tick) begin
      led_d = step_pattern(led_q, mode_q);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      key_prev_q <= 1'b1;
      state_q    <= StIdle;
      mode_q     <= ModeChase;
      led_q      <= 8'h00;
    end else begin
      sync1_q    <= KEY1_N;
      sync2_q    <= sync1_q;
      key_prev_q <= sync2_q;
      state_q    <= state_d;
      mode_q     <= sw_mode;
      led_q      <= led_d;
    end
  end

  tick_gen #(
    .LIMIT    (LIMIT),
    .STEP_SLOW(STEP_SLOW),
    .STEP_FAST(STEP_FAST)
  ) u_tick_gen (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .enable(run_en),
    .clear (clear),
    .fast  (SW[1]),
    .tick  (tick)
  );

  assign LEDR = led_q;
  assign TICK = tick;

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer with a cycle-level behavioural model.
module tb_led_sequencer;

  localparam int unsigned Limit    = 10;
  localparam int unsigned StepSlow = 2;
  localparam int unsigned StepFast = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw    = 4'b0000;
  logic       key_n = 1'b1;
  logic [7:0] ledr;
  logic       tick;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: state 0=idle 1=run 2=pause; kh = key samples from 3,2,1 edges ago.
  int m_state, m_acc, m_led, m_mode;
  bit m_tick;
  bit kh[3];

  led_sequencer #(
    .LIMIT    (Limit),
    .STEP_SLOW(StepSlow),
    .STEP_FAST(StepFast)
  ) dut (
    .CLOCK_50(clk),
    .RESET_N (rst_n),
    .SW      (sw),
    .KEY1_N  (key_n),
    .LEDR    (ledr),
    .TICK    (tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic int init_of(input int mode);
    case (mode)
      0:       return 1;
      1:       return 255;
      2:       return 85;
      default: return 0;
    endcase
  endfunction

  function automatic int stepped(input int led, input int mode);
    case (mode)
      0:       return ((led * 2) + (led / 128)) % 256;
      1, 2:    return 255 - led;
      default: return (led + 1) % 256;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_acc = 0; m_led = 0; m_mode = 0; m_tick = 0;
    kh[0] = 1; kh[1] = 1; kh[2] = 1;
  endtask

  task automatic model_edge();
    bit press;
    int ns, nmode, sum, new_led;
    press = kh[0] && !kh[1];
    kh[0] = kh[1]; kh[1] = kh[2]; kh[2] = key_n;
    nmode = int'(sw[3:2]);
    ns = m_state;
    if (m_state == 0)   ns = sw[0] ? 1 : 0;
    else if (!sw[0])    ns = 0;
    else if (press)     ns = (m_state == 1) ? 2 : 1;
    if (ns == 0)                 new_led = 0;
    else if (m_state == 0)       new_led = init_of(nmode);
    else if (nmode != m_mode)    new_led = init_of(nmode);
    else if (m_tick)             new_led = stepped(m_led, m_mode);
    else                         new_led = m_led;
    sum = m_acc + (sw[1] ? StepFast : StepSlow);
    if (ns == 0) begin
      m_acc = 0; m_tick = 0;
    end else if (m_state == 1) begin
      m_tick = (sum >= Limit);
      m_acc  = m_tick ? sum - Limit : sum;
    end else begin
      m_tick = 0;
    end
    m_led = new_led; m_mode = nmode; m_state = ns;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    n_checks++;
    if (ledr !== 8'h00 || tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: LEDR=%h TICK=%b, want 00/0", ledr, tick);
    end
    #10 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      key_n = 1'($urandom_range(0, 1));
      step();
      n_checks++;
      if (ledr !== 8'h00 || tick !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_ignore: LEDR=%h TICK=%b, want 00/0", ledr, tick);
      end
    end
    key_n = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_chase();
    int cyc, last, nt, want_led;
    bit pend;
    cyc = 0; last = -1; nt = 0; pend = 0; want_led = 0;
    sw = 4'b0001;
    for (int i = 0; i < 200 && nt < 16; i++) begin
      step(); cyc++;
      n_checks++;
      if (ledr !== 8'(m_led) || tick !== m_tick) begin
        n_fail++;
        $display("FAIL chase_model: LEDR=%h TICK=%b, want %h/%b", ledr, tick, m_led, m_tick);
      end
      if (pend) begin
        pend = 0;
        n_checks++;
        if (ledr !== 8'(want_led)) begin
          n_fail++;
          $display("FAIL chase_step: LEDR=%h, want %h after tick %0d", ledr, want_led, nt);
        end
      end
      if (tick === 1'b1) begin
        nt++;
        if (last >= 0) begin
          n_checks++;
          if (cyc - last != 5) begin
            n_fail++;
            $display("FAIL chase_spacing: gap %0d, want 5", cyc - last);
          end
        end
        last = cyc; pend = 1;
        want_led = 1 << (nt % 8);
      end
    end
    sw = 4'b0000; step(); step();
  endtask

  task automatic test_fast();
    int cyc, last, nt, want;
    cyc = 0; last = -1; nt = 0;
    sw = 4'b0011;
    for (int i = 0; i < 100 && nt < 12; i++) begin
      step(); cyc++;
      n_checks++;
      if (ledr !== 8'(m_led) || tick !== m_tick) begin
        n_fail++;
        $display("FAIL fast_model: LEDR=%h TICK=%b, want %h/%b", ledr, tick, m_led, m_tick);
      end
      if (tick === 1'b1) begin
        nt++;
        if (last >= 0) begin
          want = ((nt - 1) % 3 == 0) ? 4 : 3;
          n_checks++;
          if (cyc - last != want) begin
            n_fail++;
            $display("FAIL fast_spacing: gap %0d, want %0d at tick %0d", cyc - last, want, nt);
          end
        end
        last = cyc;
      end
    end
    for (int i = 0; i < 150; i++) begin
      sw[1] = 1'($urandom_range(0, 1));
      step();
      n_checks++;
      if (ledr !== 8'(m_led) || tick !== m_tick) begin
        n_fail++;
        $display("FAIL rate_toggle: LEDR=%h TICK=%b, want %h/%b", ledr, tick, m_led, m_tick);
      end
    end
    sw = 4'b0000; step(); step();
  endtask

  task automatic test_count();
    int nt, want_led;
    bit pend;
    nt = 0; pend = 0; want_led = 0;
    sw = 4'b1101;
    for (int i = 0; i < 1400 && nt < 257; i++) begin
      step();
      n_checks++;
      if (ledr !== 8'(m_led) || tick !== m_tick) begin
        n_fail++;
        $display("FAIL count_model: LEDR=%h TICK=%b, want %h/%b", ledr, tick, m_led, m_tick);
      end
      if (pend) begin
        pend = 0;
        n_checks++;
        if (ledr !== 8'(want_led)) begin
          n_fail++;
          $display("FAIL count_step: LEDR=%h, want %h after tick %0d", ledr, want_led, nt);
        end
      end
      if (tick === 1'b1) begin
        nt++; pend = 1;
        want_led = nt % 256;
      end
    end
    sw = 4'b0000; step(); step();
  endtask

  task automatic test_pause();
    int held_led, held_acc, cnt, gap;
    sw = 4'b0001;
    repeat (10 + $urandom_range(0, 20)) step();
    key_n = 1'b0; step(); step(); key_n = 1'b1;
    cnt = 0;
    while (m_state != 2 && cnt < 10) begin step(); cnt++; end
    step(); step();
    held_led = m_led; held_acc = m_acc;
    for (int i = 0; i < 50; i++) begin
      step();
      n_checks++;
      if (tick !== 1'b0 || ledr !== 8'(held_led)) begin
        n_fail++;
        $display("FAIL pause_hold: LEDR=%h TICK=%b, want %h/0", ledr, tick, held_led);
      end
    end
    key_n = 1'b0; step(); step(); key_n = 1'b1;
    cnt = 0;
    while (m_state != 1 && cnt < 10) begin step(); cnt++; end
    gap = (Limit - held_acc + StepSlow - 1) / StepSlow;
    cnt = 0;
    for (int i = 1; i <= 10 && cnt == 0; i++) begin
      step();
      if (tick === 1'b1) cnt = i;
    end
    n_checks++;
    if (cnt != gap) begin
      n_fail++;
      $display("FAIL resume_timing: tick after %0d cycles, want %0d (acc %0d)", cnt, gap, held_acc);
    end
  endtask

  task automatic test_idle_priority();
    int cnt;
    sw = 4'b0001; key_n = 1'b0; step(); step(); key_n = 1'b1;
    cnt = 0;
    while (m_state != 2 && cnt < 10) begin step(); cnt++; end
    repeat (4) step();
    key_n = 1'b0; cnt = 0;
    while (!(kh[0] && !kh[1]) && cnt < 6) begin step(); cnt++; end
    sw = 4'b0000;
    step();
    n_checks++;
    if (ledr !== 8'h00 || tick !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_priority: LEDR=%h TICK=%b, want 00/0", ledr, tick);
    end
    key_n = 1'b1; repeat (3) step();
    sw = 4'b0001; repeat (7) step();
    sw = 4'b0101; step();
    n_checks++;
    if (ledr !== 8'hFF) begin
      n_fail++;
      $display("FAIL mode_reload: LEDR=%h, want ff", ledr);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if (ledr !== 8'(m_led) || tick !== m_tick) begin
        n_fail++;
        $display("FAIL blink_model: LEDR=%h TICK=%b, want %h/%b", ledr, tick, m_led, m_tick);
      end
    end
    sw = 4'b0000; step(); step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      sw[0] = ($urandom_range(0, 99) < 97);
      sw[1] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 3) sw[3:2] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 10) key_n = ~key_n;
      step();
      n_checks++;
      if (ledr !== 8'(m_led) || tick !== m_tick) begin
        n_fail++;
        $display("FAIL random_model: cyc %0d LEDR=%h TICK=%b, want %h/%b",
                 i, ledr, tick, m_led, m_tick);
      end
    end
    key_n = 1'b1; sw = 4'b0000; repeat (4) step();
  endtask

  task automatic test_async_reset();
    sw = 4'b0001;
    repeat (23) step();
    @(posedge clk);
    model_edge();
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (ledr !== 8'h00 || tick !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: LEDR=%h TICK=%b, want 00/0", ledr, tick);
    end
    model_reset();
    #2 rst_n = 1'b1;
    step();
    n_checks++;
    if (ledr !== 8'h01) begin
      n_fail++;
      $display("FAIL reset_resume: LEDR=%h, want 01", ledr);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if (ledr !== 8'(m_led) || tick !== m_tick) begin
        n_fail++;
        $display("FAIL post_reset_model: LEDR=%h TICK=%b, want %h/%b", ledr, tick, m_led, m_tick);
      end
    end
  endtask

  initial begin
    test_reset();
    test_chase();
    test_fast();
    test_count();
    test_pause();
    test_idle_priority();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
